mem_initiator: RTL and testbench
================================

# mem_initiator

Requester-side controller for the unified single-port instruction/data memory. It accepts instruction-fetch requests from the fetch stage and load/store requests from the MEM stage, arbitrates between them, and drives one registered access per cycle onto the memory's read/write/func3/addr/data port. It returns the fetched word or load data with a one-cycle valid pulse. It sits between the core pipeline and the memory, replacing direct clock-phase sharing of the port.

## Interface
- `DATA_OFFSET`, 8'd128 — added to every load/store address before it is driven on `mem_addr`; fetch addresses pass through unchanged.
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `if_req` in 1 — fetch request.
- `if_addr` in 8 — fetch byte address.
- `if_ready` out 1 — fetch request accepted this cycle when `if_req & if_ready`.
- `if_valid` out 1 — one-cycle pulse; `if_instr` or `if_fault` valid.
- `if_instr` out 32 — fetched instruction.
- `if_fault` out 1 — fetch address not word-aligned.
- `ls_req` in 1 — load/store request.
- `ls_we` in 1 — 1 = store, 0 = load.
- `ls_func3` in 3 — RISC-V width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `ls_addr` in 8 — data byte address (pre-offset).
- `ls_wdata` in 32 — store data.
- `ls_ready` out 1 — load/store accepted this cycle when `ls_req & ls_ready`.
- `ls_valid` out 1 — one-cycle pulse; load data, store acknowledge, or fault.
- `ls_rdata` out 32 — load result; 0 for stores and faults.
- `ls_fault` out 1 — misaligned or illegal func3.
- `mem_read` out 1 — memory read enable (data access).
- `mem_write` out 1 — memory write enable.
- `mem_func3` out 3 — width code to memory.
- `mem_addr` out 8 — memory byte address.
- `mem_wdata` out 32 — memory write data.
- `mem_rdata` in 32 — combinational memory read data.

## Operation
- States: IDLE, ACCESS, RESP.
  - IDLE → ACCESS on any acceptance.
  - ACCESS → RESP always.
  - RESP → ACCESS on a new acceptance; otherwise RESP → IDLE.
- `if_ready`/`ls_ready` may be high only in IDLE or RESP, and at most one is high per cycle (the arbitration winner among asserted requests).
- The request is latched at acceptance. In ACCESS, the memory outputs are driven from the latch:
  - Fetch: `mem_read`=0, `mem_write`=0, `mem_func3`=010, `mem_addr`=`if_addr`.
  - Load: `mem_read`=1, `mem_addr`=`ls_addr`+`DATA_OFFSET` (8-bit wrap).
  - Store: `mem_write`=1, `mem_wdata`=`ls_wdata`.
- In any state other than ACCESS, `mem_read`, `mem_write` and `mem_addr` are 0.
- `mem_rdata` is captured at the end of ACCESS into `if_instr` (fetch) or `ls_rdata` (load).
- Fault checks are performed at acceptance:
  - Load/store faults when: func3 ∈ {011, 110, 111}; store with func3 ≥ 100; halfword with addr[0]=1; word with addr[1:0]≠0.
  - Fetch faults when `if_addr[1:0]`≠0.
  - A faulting request still passes through ACCESS, with `mem_read`=`mem_write`=0, so memory is never written. It then responds in RESP with the fault flag set and data 0.
- Response outputs hold their value after the valid pulse until the next response of the same type.

## Timing
- Accept at edge N. ACCESS occupies cycle N+1; the store write lands at edge N+2. The valid pulse is asserted during cycle N+2.
- Peak throughput: one access per 2 cycles (accept in RESP overlaps the response).
- Requesters must hold `req`, address and data stable until accepted.
- Simultaneous `if_req` and `ls_req`: decided per Configuration; the loser's ready stays 0.
- `rst_n` low at any time:
  - State goes to IDLE immediately.
  - All outputs go to 0, including `mem_write`, so an in-flight store is dropped.
  - The pending response is discarded.
- Outputs after reset: all 0.

## Configuration
- `MEM_INIT_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant flop (reset = fetch) gives priority to the source not granted last.
  - An uncontested request wins regardless of the flag.
- Undefined: fixed priority, load/store always over fetch.

## Test plan
- **Fetch:** memory holding word 0x00402083 at byte 4; `if_req`, `if_addr`=4 → `if_ready` at N; `mem_addr`=4 and `mem_read`=0 at N+1; `if_valid`=1 and `if_instr`=0x00402083 at N+2.
- **Store then load:** sw `ls_wdata`=0xDEADBEEF at `ls_addr`=12 → `mem_write`=1, `mem_addr`=140 in ACCESS, `ls_valid` ack with `ls_rdata`=0. Then lw at 12 → `ls_rdata`=0xDEADBEEF. Then lbu at 12 with func3=100 → `ls_rdata`=0x000000EF.
- **Fault:** lw at `ls_addr`=6 → `ls_fault`=1, `ls_rdata`=0, no `mem_write`. sh at addr 3 → fault, memory unchanged on read-back.
- **Contention:** `if_req` and `ls_req` both held for 4 grants.
  - Without `MEM_INIT_RR_EN`: the load/store source is granted on every grant opportunity.
  - With it: grants alternate ls, if, ls, if.
- **Reset mid-store:** assert `rst_n`=0 during ACCESS of a sw → `mem_write` falls to 0 asynchronously, the target location is unchanged, and there is no `ls_valid` after release.

Source files
------------

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator
// Description : Arbitrates fetch and load/store requests onto a single-port
//               I/D memory, one access per grant, with one-cycle responses.
//               Define MEM_INIT_RR_EN for round-robin arbitration; the
//               default build gives load/store fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_initiator #(
    parameter logic [7:0] DATA_OFFSET = 8'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic        if_fault,
    // load/store port
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_func3,
    input  logic [7:0]  ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        ls_fault,
    // memory port
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_func3,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] c_F3_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_window;
    logic        w_grant_ls;
    logic        w_grant_if;
    logic        w_accept;
    logic        w_ls_fault;
    logic        w_if_fault;
    logic        w_in_access;

    logic        r_is_ls;
    logic        r_we;
    logic [2:0]  r_func3;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;

    logic [31:0] r_if_instr;
    logic        r_if_fault;
    logic [31:0] r_ls_rdata;
    logic        r_ls_fault;

    // ------------------------------------------------------------------
    // Arbitration: a new request may only be taken in IDLE or RESP
    // ------------------------------------------------------------------
    assign w_window = (r_state == IDLE) || (r_state == RESP);

`ifdef MEM_INIT_RR_EN
    logic r_last_ls;

    // Contested: favour whichever source did not win last time
    assign w_grant_ls = ls_req & (~if_req | ~r_last_ls);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_ls <= 1'b0;
        end else if (w_accept) begin
            r_last_ls <= ls_ready;
        end
    end
`else
    assign w_grant_ls = ls_req;
`endif

    assign w_grant_if = if_req & ~w_grant_ls;
    assign ls_ready   = w_window & w_grant_ls;
    assign if_ready   = w_window & w_grant_if;
    assign w_accept   = ls_ready | if_ready;

    // ------------------------------------------------------------------
    // Fault classification, evaluated on the request as presented
    // ------------------------------------------------------------------
    always_comb begin
        w_ls_fault = 1'b1;
        case (ls_func3)
            3'b000:  w_ls_fault = 1'b0;
            3'b001:  w_ls_fault = ls_addr[0];
            3'b010:  w_ls_fault = |ls_addr[1:0];
            3'b100:  w_ls_fault = ls_we;
            3'b101:  w_ls_fault = ls_we | ls_addr[0];
            default: w_ls_fault = 1'b1;
        endcase
    end

    assign w_if_fault = |if_addr[1:0];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_accept ? ACCESS : IDLE;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = w_accept ? ACCESS : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch; the data offset is applied here so ACCESS is a pure
    // register decode onto the memory port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_ls <= 1'b0;
            r_we    <= 1'b0;
            r_func3 <= 3'b000;
            r_addr  <= 8'h00;
            r_wdata <= 32'h0000_0000;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_is_ls <= ls_ready;
            r_we    <= ls_ready & ls_we;
            r_func3 <= ls_ready ? ls_func3 : c_F3_WORD;
            r_addr  <= ls_ready ? (ls_addr + DATA_OFFSET) : if_addr;
            r_wdata <= ls_ready ? ls_wdata : 32'h0000_0000;
            r_fault <= ls_ready ? w_ls_fault : w_if_fault;
        end
    end

    // ------------------------------------------------------------------
    // Memory port: quiet outside ACCESS; a faulting access never strobes
    // ------------------------------------------------------------------
    assign w_in_access = (r_state == ACCESS);

    assign mem_read  = w_in_access & r_is_ls & ~r_we & ~r_fault;
    assign mem_write = w_in_access & r_is_ls &  r_we & ~r_fault;
    assign mem_func3 = w_in_access ? r_func3 : 3'b000;
    assign mem_addr  = w_in_access ? r_addr  : 8'h00;
    assign mem_wdata = (w_in_access & r_we) ? r_wdata : 32'h0000_0000;

    // ------------------------------------------------------------------
    // Response capture at the end of ACCESS; values hold until the next
    // response of the same kind
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_instr <= 32'h0000_0000;
            r_if_fault <= 1'b0;
        end else if (w_in_access && !r_is_ls) begin
            r_if_instr <= r_fault ? 32'h0000_0000 : mem_rdata;
            r_if_fault <= r_fault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ls_rdata <= 32'h0000_0000;
            r_ls_fault <= 1'b0;
        end else if (w_in_access && r_is_ls) begin
            r_ls_rdata <= (r_fault || r_we) ? 32'h0000_0000 : mem_rdata;
            r_ls_fault <= r_fault;
        end
    end

    assign if_valid = (r_state == RESP) & ~r_is_ls;
    assign ls_valid = (r_state == RESP) &  r_is_ls;
    assign if_instr = r_if_instr;
    assign if_fault = r_if_fault;
    assign ls_rdata = r_ls_rdata;
    assign ls_fault = r_ls_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_initiator
// Description : Directed self-checking bench for mem_initiator with a
//               byte-addressed memory model (width/sign handled in memory).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_initiator;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_fault;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_func3;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ready;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic        ls_fault;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total;
    int bad;

    logic [7:0] mem [0:255];

    mem_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_fault  (if_fault),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_func3  (ls_func3),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ready  (ls_ready),
        .ls_valid  (ls_valid),
        .ls_rdata  (ls_rdata),
        .ls_fault  (ls_fault),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_func3 (mem_func3),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read with width/sign per func3
    always_comb begin
        case (mem_func3)
            3'b000:  mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
            3'b001:  mem_rdata = {{16{mem[mem_addr + 8'd1][7]}}, mem[mem_addr + 8'd1], mem[mem_addr]};
            3'b100:  mem_rdata = {24'h0, mem[mem_addr]};
            3'b101:  mem_rdata = {16'h0, mem[mem_addr + 8'd1], mem[mem_addr]};
            default: mem_rdata = {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                                  mem[mem_addr + 8'd1], mem[mem_addr]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_func3 != 3'b000) mem[mem_addr + 8'd1] <= mem_wdata[15:8];
            if (mem_func3 == 3'b010) begin
                mem[mem_addr + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    function automatic logic [31:0] mword(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Fetch transaction; entered and left just after a rising edge in IDLE
    task automatic if_txn(input string tag, input logic [7:0] addr,
                          input logic [31:0] exp_instr, input logic exp_fault);
        if_req  = 1'b1;
        if_addr = addr;
        @(negedge clk);
        chk($sformatf("%s_ready", tag), {31'd0, if_ready}, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_acc_addr", tag), {24'd0, mem_addr}, {24'd0, addr});
        chk($sformatf("%s_acc_rw", tag), {30'd0, mem_read, mem_write}, 32'd0);
        chk($sformatf("%s_acc_f3", tag), {29'd0, mem_func3}, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("%s_valid", tag), {31'd0, if_valid}, 32'd1);
        chk($sformatf("%s_instr", tag), if_instr, exp_instr);
        chk($sformatf("%s_fault", tag), {31'd0, if_fault}, {31'd0, exp_fault});
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("%s_idle_valid", tag), {31'd0, if_valid}, 32'd0);
        chk($sformatf("%s_hold", tag), if_instr, exp_instr);
        @(posedge clk); #1;
    endtask

    // Load/store transaction with hand-computed expectations
    task automatic ls_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          input logic exp_wr, input logic exp_rd, input logic [7:0] exp_addr,
                          input logic [31:0] exp_rdata, input logic exp_fault);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_func3 = f3;
        ls_addr  = addr;
        ls_wdata = wdata;
        @(negedge clk);
        chk($sformatf("%s_ready", tag), {30'd0, ls_ready, if_ready}, 32'd2);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_acc_wr", tag), {31'd0, mem_write}, {31'd0, exp_wr});
        chk($sformatf("%s_acc_rd", tag), {31'd0, mem_read}, {31'd0, exp_rd});
        chk($sformatf("%s_acc_addr", tag), {24'd0, mem_addr}, {24'd0, exp_addr});
        chk($sformatf("%s_acc_f3", tag), {29'd0, mem_func3}, {29'd0, f3});
        if (exp_wr) chk($sformatf("%s_acc_wdata", tag), mem_wdata, wdata);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("%s_valid", tag), {31'd0, ls_valid}, 32'd1);
        chk($sformatf("%s_rdata", tag), ls_rdata, exp_rdata);
        chk($sformatf("%s_fault", tag), {31'd0, ls_fault}, {31'd0, exp_fault});
        chk($sformatf("%s_resp_addr", tag), {24'd0, mem_addr}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("%s_idle_valid", tag), {31'd0, ls_valid}, 32'd0);
        chk($sformatf("%s_hold", tag), ls_rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    logic [3:0] exp_ls_grant;
    logic       got;
    int         vcnt;

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = 8'h00;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_func3 = 3'b000;
        ls_addr  = 8'h00;
        ls_wdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[7], mem[6], mem[5], mem[4]} = 32'h0040_2083;

        // Reset state
        @(posedge clk); #1;
        chk("rst_outs", {if_ready, ls_ready, if_valid, ls_valid, mem_read, mem_write,
                         if_fault, ls_fault, mem_func3, 23'd0}, 32'd0);
        chk("rst_data", if_instr | ls_rdata | mem_wdata | {24'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fetch
        if_txn("fetch4", 8'd4, 32'h0040_2083, 1'b0);

        // Store then loads of several widths
        ls_txn("sw12",  1'b1, 3'b010, 8'd12, 32'hDEAD_BEEF, 1'b1, 1'b0, 8'd140, 32'h0, 1'b0);
        chk("sw12_mem", mword(140), 32'hDEAD_BEEF);
        ls_txn("lw12",  1'b0, 3'b010, 8'd12, 32'h0, 1'b0, 1'b1, 8'd140, 32'hDEAD_BEEF, 1'b0);
        ls_txn("lbu12", 1'b0, 3'b100, 8'd12, 32'h0, 1'b0, 1'b1, 8'd140, 32'h0000_00EF, 1'b0);
        ls_txn("lb13",  1'b0, 3'b000, 8'd13, 32'h0, 1'b0, 1'b1, 8'd141, 32'hFFFF_FFBE, 1'b0);
        ls_txn("lh14",  1'b0, 3'b001, 8'd14, 32'h0, 1'b0, 1'b1, 8'd142, 32'hFFFF_DEAD, 1'b0);
        ls_txn("lhu12", 1'b0, 3'b101, 8'd12, 32'h0, 1'b0, 1'b1, 8'd140, 32'h0000_BEEF, 1'b0);

        // Faults
        ls_txn("lw6_flt",  1'b0, 3'b010, 8'd6,  32'h0, 1'b0, 1'b0, 8'd134, 32'h0, 1'b1);
        ls_txn("sh3_flt",  1'b1, 3'b001, 8'd3,  32'h0000_1234, 1'b0, 1'b0, 8'd131, 32'h0, 1'b1);
        chk("sh3_mem", {16'd0, mem[132], mem[131]}, 32'd0);
        ls_txn("lbu3_rb",  1'b0, 3'b100, 8'd3,  32'h0, 1'b0, 1'b1, 8'd131, 32'h0, 1'b0);
        ls_txn("f3_011",   1'b0, 3'b011, 8'd0,  32'h0, 1'b0, 1'b0, 8'd128, 32'h0, 1'b1);
        ls_txn("st_f3_100", 1'b1, 3'b100, 8'd16, 32'h0000_00FF, 1'b0, 1'b0, 8'd144, 32'h0, 1'b1);
        chk("st_f3_100_mem", {24'd0, mem[144]}, 32'd0);
        ls_txn("sb16",     1'b1, 3'b000, 8'd16, 32'h1234_56A5, 1'b1, 1'b0, 8'd144, 32'h0, 1'b0);
        ls_txn("lbu16",    1'b0, 3'b100, 8'd16, 32'h0, 1'b0, 1'b1, 8'd144, 32'h0000_00A5, 1'b0);
        chk("sb16_nbr", {24'd0, mem[145]}, 32'd0);
        if_txn("fetch2_flt", 8'd2, 32'h0, 1'b1);

        // Contention: last grant before this point was a fetch
`ifdef MEM_INIT_RR_EN
        exp_ls_grant = 4'b0101;
`else
        exp_ls_grant = 4'b1111;
`endif
        if_req   = 1'b1;
        if_addr  = 8'd4;
        ls_req   = 1'b1;
        ls_we    = 1'b0;
        ls_func3 = 3'b010;
        ls_addr  = 8'd12;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                @(negedge clk);
                if (if_ready || ls_ready) got = 1'b1;
                else @(posedge clk);
            end
            chk($sformatf("cont%0d_found", g), {31'd0, got}, 32'd1);
            chk($sformatf("cont%0d_excl", g), {31'd0, if_ready & ls_ready}, 32'd0);
            chk($sformatf("cont%0d_ls", g), {31'd0, ls_ready}, {31'd0, exp_ls_grant[g]});
            @(posedge clk);
        end
        #1;
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during ACCESS of a store
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_func3 = 3'b010;
        ls_addr  = 8'd12;
        ls_wdata = 32'h1122_3344;
        @(negedge clk);
        chk("rst_sw_ready", {31'd0, ls_ready}, 32'd1);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        chk("rst_sw_acc_wr", {31'd0, mem_write}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_wr", {31'd0, mem_write}, 32'd0);
        chk("rst_async_addr", {24'd0, mem_addr}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ls_valid) vcnt++;
        end
        chk("rst_no_valid", vcnt, 32'd0);
        chk("rst_mem_kept", mword(140), 32'hDEAD_BEEF);
        chk("rst_rdata_clr", ls_rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
